// File: rtl/operand_entry_sequencer.sv
// Operand entry sequencer: front-end control for the switch-driven ALU lab.
// Conditions the raw "enter" (BTNC) and "restart" (BTNU) pushbuttons with a
// two-flop synchronizer plus a level debouncer, then steps a five-stage entry
// FSM. Each accepted enter press issues a one-cycle load strobe (r0..r4) to
// the downstream operand/opcode register bank and advances the stage.
module operand_entry_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESET,
  input  logic       BTNC,
  input  logic       BTNU,
  output logic       r0,
  output logic       r1,
  output logic       r2,
  output logic       r3,
  output logic       r4,
  output logic [2:0] stage,
  output logic       show_result
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] StOp1Lo  = 3'd0;
  localparam logic [2:0] StOp1Hi  = 3'd1;
  localparam logic [2:0] StOp2Lo  = 3'd2;
  localparam logic [2:0] StOp2Hi  = 3'd3;
  localparam logic [2:0] StOpcode = 3'd4;
  localparam logic [2:0] StResult = 3'd5;

  // Bit 0 = enter (BTNC), bit 1 = restart (BTNU).
  logic [1:0] btn_raw;
  logic [1:0] press;

  assign btn_raw = {BTNU, BTNC};

  for (genvar i = 0; i < 2; i++) begin : g_debounce
    logic            sync1_q;
    logic            sync2_q;
    logic            acc_q;
    logic            acc_d;
    logic            acc_dly_q;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Debounce counter: runs while the synchronized level disagrees with the
    // accepted level and commits the new level on the final count.
    always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (sync2_q == acc_q) begin
        cnt_d = '0;
      end else if (cnt_q == CntMax) begin
        acc_d = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    // Synchronizer, accepted level and its delayed copy for edge detection.
    always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
      if (CPU_RESET) begin
        sync1_q   <= 1'b0;
        sync2_q   <= 1'b0;
        acc_q     <= 1'b0;
        acc_dly_q <= 1'b0;
        cnt_q     <= '0;
      end else begin
        sync1_q   <= btn_raw[i];
        sync2_q   <= sync1_q;
        acc_q     <= acc_d;
        acc_dly_q <= acc_q;
        cnt_q     <= cnt_d;
      end
    end

    // One-cycle pulse per accepted rising level.
    assign press[i] = acc_q & ~acc_dly_q;
  end

  logic       enter_press;
  logic       restart_press;
  logic [2:0] state_q;
  logic [2:0] state_d;
  logic [4:0] strobe_q;
  logic [4:0] strobe_d;
  logic       show_result_q;

  assign enter_press   = press[0];
  assign restart_press = press[1];

  // Next-state and strobe decode; restart overrides a coincident enter.
  always_comb begin
    state_d  = state_q;
    strobe_d = '0;
    if (restart_press) begin
      state_d = StOp1Lo;
    end else begin
      case (state_q)
        StOp1Lo, StOp1Hi, StOp2Lo, StOp2Hi, StOpcode: begin
          if (enter_press) begin
            strobe_d = 5'b00001 << state_q;
            state_d  = state_q + 3'd1;
          end
        end
        StResult: begin
          // Latched operands stay in the bank until overwritten stage by stage.
          if (enter_press) begin
            state_d = StOp1Lo;
          end
        end
        default: begin
          state_d = StOp1Lo;
        end
      endcase
    end
  end

  // State, strobe and display-select registers; reset cuts any strobe in flight.
  always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      state_q       <= StOp1Lo;
      strobe_q      <= '0;
      show_result_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      strobe_q      <= strobe_d;
      // Registered from the next state so it changes on the same edge as stage.
      show_result_q <= (state_d == StResult);
    end
  end

  assign r0          = strobe_q[0];
  assign r1          = strobe_q[1];
  assign r2          = strobe_q[2];
  assign r3          = strobe_q[3];
  assign r4          = strobe_q[4];
  assign stage       = state_q;
  assign show_result = show_result_q;

endmodule
